// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: FSM states, frame sync marker
// and the CMD byte layout used to recognise a register-write command.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_DATA,
        ST_GET_CHK,
        ST_COMMIT
    } state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         CMD_WRITE_BIT     = 7;
    localparam logic [7:0] CMD_OPCODE_MASK   = 8'hF0;

    // Only the write opcode (bit 7 set, bits 6:4 clear) is legal.
    function automatic logic is_write_cmd(input logic [7:0] cmd);
        return (cmd & CMD_OPCODE_MASK) == (8'h01 << CMD_WRITE_BIT);
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte watchdog: counts enabled clocks since the last clear and flags
// a single-cycle expiry on the last count unless a clear lands in that cycle.
module uart_byte_timer #(
    parameter int TIMEOUT_CLKS = 52080
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int             W    = $clog2(TIMEOUT_CLKS);
    localparam logic [W-1:0]   LAST = W'(TIMEOUT_CLKS - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        expired_o = enable_i && !clear_i && (count_q == LAST);
        count_d   = count_q;
        if (clear_i || expired_o) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses SYNC/CMD/DATA/CHK frames from a UART byte stream into one-cycle
// register-write strobes, with checksum/opcode and inter-byte timeout errors.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CLKS = 52080,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [7:0] RX_DATA,
    input  logic       RX_DONE,
    output logic       WR_EN,
    output logic [3:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    output logic       ERR_CHK,
    output logic       ERR_TIMEOUT,
    output logic [7:0] FRAME_CNT,
    output logic       BUSY
);

    state_e     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] data_q, data_d;
    logic       wr_en_q, wr_en_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       err_chk_q, err_chk_d;
    logic       err_to_q, err_to_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       frame_good;
    logic       timer_clear, timer_enable, timer_expired;

    // A strobe always restarts the gap measurement, so expiry and a byte never collide.
    assign timer_clear  = RX_DONE || (state_q == ST_IDLE) || (state_q == ST_COMMIT);
    assign timer_enable = (state_q == ST_GET_CMD) || (state_q == ST_GET_DATA) ||
                          (state_q == ST_GET_CHK);

    uart_byte_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timer (
        .clk_i    (CLOCK_50),
        .rst_i    (RESET),
        .clear_i  (timer_clear),
        .enable_i (timer_enable),
        .expired_o(timer_expired)
    );

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            data_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_chk_q   <= 1'b0;
            err_to_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            err_chk_q   <= err_chk_d;
            err_to_q    <= err_to_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (RX_DONE && RX_DATA == SYNC_BYTE) state_d = ST_GET_CMD;
            ST_GET_CMD:  if (RX_DONE) state_d = ST_GET_DATA;
                         else if (timer_expired) state_d = ST_IDLE;
            ST_GET_DATA: if (RX_DONE) state_d = ST_GET_CHK;
                         else if (timer_expired) state_d = ST_IDLE;
            ST_GET_CHK:  if (RX_DONE) state_d = ST_COMMIT;
                         else if (timer_expired) state_d = ST_IDLE;
            ST_COMMIT:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Result pulses are registered on the CHK strobe so they appear during COMMIT.
    always_comb begin
        cmd_d       = cmd_q;
        data_d      = data_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_chk_d   = 1'b0;
        err_to_d    = timer_expired;
        frame_cnt_d = frame_cnt_q;
        frame_good  = is_write_cmd(cmd_q) && (RX_DATA == (cmd_q ^ data_q));
        if (RX_DONE) begin
            unique case (state_q)
                ST_GET_CMD:  cmd_d = RX_DATA;
                ST_GET_DATA: data_d = RX_DATA;
                ST_GET_CHK: begin
                    if (frame_good) begin
                        wr_en_d     = 1'b1;
                        wr_addr_d   = cmd_q[3:0];
                        wr_data_d   = data_q;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        err_chk_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign WR_EN       = wr_en_q;
    assign WR_ADDR     = wr_addr_q;
    assign WR_DATA     = wr_data_q;
    assign ERR_CHK     = err_chk_q;
    assign ERR_TIMEOUT = err_to_q;
    assign FRAME_CNT   = frame_cnt_q;
    assign BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomised and directed bench for uart_cmd_parser: a byte-stream reference
// model queues expected result pulses, a negedge monitor pops and compares them.
module tb_uart_cmd_parser;

    localparam int TMO    = 64;
    localparam int EV_WR  = 0;
    localparam int EV_CHK = 1;
    localparam int EV_TMO = 2;

    typedef struct {
        int         kind;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic [7:0] RX_DATA;
    logic       RX_DONE;
    logic       WR_EN;
    logic [3:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic       ERR_CHK;
    logic       ERR_TIMEOUT;
    logic [7:0] FRAME_CNT;
    logic       BUSY;

    int         assertCount = 0;
    int         failCount   = 0;

    ev_t        expQ[$];
    int         inFrame;
    logic [7:0] frameBytes[4];
    bit         justCommitted;
    int         idleAcc;
    logic [7:0] expCnt;
    logic [3:0] lastAddr;
    logic [7:0] lastData;
    int         monGot;
    ev_t        monEv;

    uart_cmd_parser #(
        .TIMEOUT_CLKS(TMO),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .RX_DATA    (RX_DATA),
        .RX_DONE    (RX_DONE),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .ERR_CHK    (ERR_CHK),
        .ERR_TIMEOUT(ERR_TIMEOUT),
        .FRAME_CNT  (FRAME_CNT),
        .BUSY       (BUSY)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushEv(input int kind, input logic [3:0] addr, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Reference: a frame is SYNC then three bytes; CMD must lie in 80..8F and CHK = CMD^DATA.
    task automatic modelByte(input logic [7:0] b, input int gap);
        if (inFrame > 0 && gap > TMO) begin
            pushEv(EV_TMO, 4'h0, 8'h00);
            inFrame = 0;
        end
        if (justCommitted && gap == 1) begin
            justCommitted = 1'b0;
            return;
        end
        justCommitted = 1'b0;
        if (inFrame == 0) begin
            if (b == 8'hA5) inFrame = 1;
        end else begin
            frameBytes[inFrame] = b;
            inFrame++;
            if (inFrame == 4) begin
                if (frameBytes[1] >= 8'h80 && frameBytes[1] <= 8'h8F &&
                    frameBytes[3] == (frameBytes[1] ^ frameBytes[2])) begin
                    pushEv(EV_WR, frameBytes[1][3:0], frameBytes[2]);
                    expCnt   = expCnt + 8'd1;
                    lastAddr = frameBytes[1][3:0];
                    lastData = frameBytes[2];
                end else begin
                    pushEv(EV_CHK, 4'h0, 8'h00);
                end
                inFrame       = 0;
                justCommitted = 1'b1;
            end
        end
    endtask

    // Strobe one byte gap clocks after the previous strobe (gap >= 1).
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        modelByte(b, gap + idleAcc);
        idleAcc = 0;
        repeat (gap - 1) @(negedge CLOCK_50);
        RX_DATA = b;
        RX_DONE = 1'b1;
        @(negedge CLOCK_50);
        RX_DONE = 1'b0;
        RX_DATA = 8'h00;
    endtask

    task automatic idle(input int n);
        if (inFrame > 0 && idleAcc + n > TMO) begin
            pushEv(EV_TMO, 4'h0, 8'h00);
            inFrame = 0;
        end
        idleAcc += n;
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic sendFrame(input logic [7:0] c, input logic [7:0] d,
                             input logic [7:0] k, input int gap);
        applyStimulus(8'hA5, gap);
        applyStimulus(c, gap);
        applyStimulus(d, gap);
        applyStimulus(k, gap);
    endtask

    function automatic int randGap(input bit allowOdd);
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return TMO;
        if (r == 1 && allowOdd) return TMO + 1;
        if (r == 2 && allowOdd) return 1;
        return int'($urandom_range(2, 9));
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wr_en"}, 32'(WR_EN), 32'd0);
        checkOutput({tag, "_wr_addr"}, 32'(WR_ADDR), 32'd0);
        checkOutput({tag, "_wr_data"}, 32'(WR_DATA), 32'd0);
        checkOutput({tag, "_err_chk"}, 32'(ERR_CHK), 32'd0);
        checkOutput({tag, "_err_timeout"}, 32'(ERR_TIMEOUT), 32'd0);
        checkOutput({tag, "_frame_cnt"}, 32'(FRAME_CNT), 32'd0);
        checkOutput({tag, "_busy"}, 32'(BUSY), 32'd0);
    endtask

    task automatic modelReset();
        inFrame       = 0;
        justCommitted = 1'b0;
        idleAcc       = 0;
        expCnt        = 8'd0;
        lastAddr      = 4'h0;
        lastData      = 8'h00;
    endtask

    // Monitor: every result pulse must match the oldest expected event.
    always @(negedge CLOCK_50) begin
        if (!RESET && (WR_EN || ERR_CHK || ERR_TIMEOUT)) begin
            monGot = WR_EN ? EV_WR : (ERR_CHK ? EV_CHK : EV_TMO);
            checkOutput("pulse_exclusive", 32'(WR_EN) + 32'(ERR_CHK) + 32'(ERR_TIMEOUT), 32'd1);
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_event: got kind %0d, expected no event", monGot);
            end else begin
                monEv = expQ.pop_front();
                checkOutput("event_kind", 32'(monGot), 32'(monEv.kind));
                if (monEv.kind == EV_WR && monGot == EV_WR) begin
                    checkOutput("wr_addr", 32'(WR_ADDR), 32'(monEv.addr));
                    checkOutput("wr_data", 32'(WR_DATA), 32'(monEv.data));
                end
            end
        end
    end

    initial begin
        logic [7:0] c, d, k;
        int         kind;

        RESET   = 1'b1;
        RX_DONE = 1'b0;
        RX_DATA = 8'h00;
        modelReset();
        repeat (3) @(negedge CLOCK_50);
        checkAllZero("reset");
        RESET = 1'b0;
        idle(3);

        $display("[TB] good frame A5 83 5C DF");
        sendFrame(8'h83, 8'h5C, 8'hDF, 20);
        idle(5);
        checkOutput("cnt_after_good", 32'(FRAME_CNT), 32'(expCnt));
        checkOutput("busy_after_good", 32'(BUSY), 32'd0);

        $display("[TB] bad checksum frame");
        sendFrame(8'h83, 8'h5C, 8'h00, 20);
        idle(5);
        checkOutput("cnt_after_bad", 32'(FRAME_CNT), 32'(expCnt));
        checkOutput("addr_hold", 32'(WR_ADDR), 32'(lastAddr));
        checkOutput("data_hold", 32'(WR_DATA), 32'(lastData));

        $display("[TB] timeout after A5 83");
        applyStimulus(8'hA5, 10);
        applyStimulus(8'h83, 10);
        idle(70);
        checkOutput("busy_after_timeout", 32'(BUSY), 32'd0);
        sendFrame(8'h81, 8'h22, 8'hA3, 7);
        idle(5);
        checkOutput("cnt_after_timeout_frame", 32'(FRAME_CNT), 32'(expCnt));

        $display("[TB] leading junk then good frame");
        applyStimulus(8'h11, 4);
        applyStimulus(8'h22, 4);
        sendFrame(8'h8C, 8'h3E, 8'hB2, 4);
        idle(5);
        checkOutput("cnt_after_junk", 32'(FRAME_CNT), 32'(expCnt));

        $display("[TB] illegal opcodes, sync byte inside frame");
        sendFrame(8'h93, 8'h00, 8'h93, 3);
        sendFrame(8'h03, 8'h10, 8'h13, 3);
        sendFrame(8'h8A, 8'hA5, 8'h2F, 3);
        idle(5);
        checkOutput("cnt_after_mixed", 32'(FRAME_CNT), 32'(expCnt));

        $display("[TB] byte exactly on expiry, one clock late");
        applyStimulus(8'hA5, 10);
        applyStimulus(8'h84, TMO);
        applyStimulus(8'h11, TMO);
        applyStimulus(8'h95, TMO);
        applyStimulus(8'hA5, 10);
        applyStimulus(8'h84, TMO + 1);
        idle(5);
        checkOutput("cnt_after_expiry", 32'(FRAME_CNT), 32'(expCnt));
        checkOutput("busy_after_late", 32'(BUSY), 32'd0);

        $display("[TB] reset mid-frame");
        applyStimulus(8'hA5, 20);
        applyStimulus(8'h83, 20);
        applyStimulus(8'h5C, 20);
        checkOutput("queue_before_reset", 32'(expQ.size()), 32'd0);
        RESET = 1'b1;
        #1;
        checkAllZero("midreset");
        modelReset();
        repeat (2) @(negedge CLOCK_50);
        RESET = 1'b0;
        applyStimulus(8'hDF, 5);
        idle(5);
        checkOutput("cnt_after_reset_df", 32'(FRAME_CNT), 32'd0);

        $display("[TB] 256 good frames for counter wrap");
        for (int i = 0; i < 256; i++) begin
            c = {4'h8, 4'($urandom_range(0, 15))};
            d = 8'($urandom);
            applyStimulus(8'hA5, randGap(1'b0));
            applyStimulus(c, randGap(1'b0));
            applyStimulus(d, randGap(1'b0));
            applyStimulus(c ^ d, randGap(1'b0));
        end
        idle(5);
        checkOutput("cnt_wrap_model", 32'(expCnt), 32'd0);
        checkOutput("cnt_wrap", 32'(FRAME_CNT), 32'd0);

        $display("[TB] randomised mixed traffic");
        for (int i = 0; i < 150; i++) begin
            c    = {4'h8, 4'($urandom_range(0, 15))};
            d    = 8'($urandom);
            k    = c ^ d;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) k = k ^ (8'h01 << $urandom_range(0, 7));
            if (kind == 1) c = 8'($urandom);
            if (kind == 2) applyStimulus(8'($urandom), randGap(1'b1));
            applyStimulus(8'hA5, randGap(1'b1));
            applyStimulus(c, randGap(1'b1));
            if (kind == 3) begin
                idle(70);
            end else begin
                applyStimulus(d, randGap(1'b1));
                applyStimulus(k, randGap(1'b1));
            end
            if (i % 32 == 31) begin
                idle(TMO + 6);
                checkOutput("cnt_random", 32'(FRAME_CNT), 32'(expCnt));
            end
        end
        idle(TMO + 10);
        checkOutput("cnt_final", 32'(FRAME_CNT), 32'(expCnt));
        checkOutput("pending_events", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
